// File: rtl/nes_pkg.sv
// nes_pkg: shared constants and types for the NES joypad block.
package nes_pkg;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [15:0] JOY_PORT1 = 16'h4016;
  localparam logic [15:0] JOY_PORT2 = 16'h4017;
  typedef enum logic [2:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK, ST_SKIP} dec_state_t;
  typedef struct packed {
    logic       hit;
    logic       player;
    logic [2:0] idx;
  } key_t;
  function automatic key_t key_of(input logic player, input int idx);
    return '{hit: 1'b1, player: player, idx: 3'(idx)};
  endfunction
endpackage

// File: rtl/nes_joypad_if.sv
// nes_joypad_if: PS/2 byte stream, CPU pad-port bus and live button outputs.
interface nes_joypad_if;
  logic [7:0]  ps2_data;
  logic        ps2_en;
  logic [15:0] ea;
  logic [7:0]  din;
  logic        wreq;
  logic        rd;
  logic        cpu_stb;
  logic [7:0]  dout;
  logic [7:0]  joy1;
  logic [7:0]  joy2;
  modport master (output ps2_data, ps2_en, ea, din, wreq, rd, cpu_stb, input dout, joy1, joy2);
  modport slave  (input ps2_data, ps2_en, ea, din, wreq, rd, cpu_stb, output dout, joy1, joy2);
endinterface

// File: rtl/ps2_keymap.sv
// ps2_keymap: maps an (extended, scancode) pair to a player/button, hit=0 when unmapped.
module ps2_keymap
  import nes_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output key_t       key
);
  always_comb begin
    key = '0;
    case ({ext, code})
      {1'b0, 8'h1A}: key = key_of(1'b0, BTN_A);
      {1'b0, 8'h22}: key = key_of(1'b0, BTN_B);
      {1'b0, 8'h21}: key = key_of(1'b0, BTN_SELECT);
      {1'b0, 8'h2A}: key = key_of(1'b0, BTN_START);
      {1'b1, 8'h75}: key = key_of(1'b0, BTN_UP);
      {1'b1, 8'h72}: key = key_of(1'b0, BTN_DOWN);
      {1'b1, 8'h6B}: key = key_of(1'b0, BTN_LEFT);
      {1'b1, 8'h74}: key = key_of(1'b0, BTN_RIGHT);
      {1'b0, 8'h31}: key = key_of(1'b1, BTN_A);
      {1'b0, 8'h3A}: key = key_of(1'b1, BTN_B);
      {1'b0, 8'h41}: key = key_of(1'b1, BTN_SELECT);
      {1'b0, 8'h49}: key = key_of(1'b1, BTN_START);
      {1'b0, 8'h75}: key = key_of(1'b1, BTN_UP);
      {1'b0, 8'h72}: key = key_of(1'b1, BTN_DOWN);
      {1'b0, 8'h6B}: key = key_of(1'b1, BTN_LEFT);
      {1'b0, 8'h74}: key = key_of(1'b1, BTN_RIGHT);
      default:       key = '0;
    endcase
  end
endmodule

// File: rtl/nes_joypad.sv
// nes_joypad: PS/2 set-2 decoder into two NES pads plus $4016/$4017 strobe/serial ports.
module nes_joypad
  import nes_pkg::*;
#(
  parameter int         PREFIX_TIMEOUT = 500000,
  parameter logic [7:0] OPEN_BUS       = 8'h40
) (
  input logic         clk,
  input logic         rst,
  nes_joypad_if.slave bus
);
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(PREFIX_TIMEOUT - 1);
  dec_state_t state;
  logic [2:0] skip;
  logic [TW-1:0] cnt;
  logic [7:0] joy1, joy2, sr1, sr2;
  logic strobe, is_prefix, is_make, is_brk, ext, wr16, rd16, rd17;
  key_t key;
  assign is_prefix = bus.ps2_data inside {PS2_BREAK, PS2_EXT, PS2_PAUSE};
  assign is_make = bus.ps2_en && ((state == ST_IDLE && !is_prefix) || (state == ST_EXT && bus.ps2_data != PS2_BREAK));
  assign is_brk = bus.ps2_en && (state == ST_BRK || state == ST_EXT_BRK);
  assign ext = state == ST_EXT || state == ST_EXT_BRK;
  assign wr16 = bus.cpu_stb && bus.wreq && bus.ea == JOY_PORT1;
  assign rd16 = bus.cpu_stb && bus.rd && bus.ea == JOY_PORT1;
  assign rd17 = bus.cpu_stb && bus.rd && bus.ea == JOY_PORT2;
  ps2_keymap u_keymap (.ext(ext), .code(bus.ps2_data), .key(key));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      skip  <= '0;
      cnt   <= '0;
    end else begin
      cnt <= bus.ps2_en ? '0 : (cnt == TMAX ? cnt : cnt + TW'(1));
      if (bus.ps2_en) begin
        case (state)
          ST_IDLE: begin
            state <= bus.ps2_data == PS2_BREAK ? ST_BRK :
                     bus.ps2_data == PS2_EXT   ? ST_EXT :
                     bus.ps2_data == PS2_PAUSE ? ST_SKIP : ST_IDLE;
            skip  <= 3'd7;
          end
          ST_EXT:  state <= bus.ps2_data == PS2_BREAK ? ST_EXT_BRK : ST_IDLE;
          ST_SKIP: begin
            skip  <= skip - 3'd1;
            state <= skip == 3'd1 ? ST_IDLE : ST_SKIP;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE && cnt == TMAX) begin
        state <= ST_IDLE;
      end
    end
  end
  // Latching below reads joy1/joy2 before this edge's key update lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      joy1   <= '0;
      joy2   <= '0;
      sr1    <= '0;
      sr2    <= '0;
      strobe <= 1'b0;
    end else begin
      if (key.hit && (is_make || is_brk)) begin
        if (key.player) joy2[key.idx] <= is_make;
        else            joy1[key.idx] <= is_make;
      end
      strobe <= wr16 ? bus.din[0] : strobe;
      sr1    <= strobe ? joy1 : rd16 ? {1'b1, sr1[7:1]} : sr1;
      sr2    <= strobe ? joy2 : rd17 ? {1'b1, sr2[7:1]} : sr2;
    end
  end
  always_comb begin
    bus.dout = bus.ea == JOY_PORT1 ? {OPEN_BUS[7:1], strobe ? joy1[0] : sr1[0]} :
               bus.ea == JOY_PORT2 ? {OPEN_BUS[7:1], strobe ? joy2[0] : sr2[0]} : 8'h00;
  end
  assign bus.joy1 = joy1;
  assign bus.joy2 = joy2;
endmodule
